// File: rtl/gps_pkg.sv
// Shared definitions for the GPS receive path: UART receiver states, default
// bit timing and the ASCII framing characters the NMEA parser looks for.
package gps_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // 50 MHz system clock, 9600 baud GPS UART
  localparam int CLKS_PER_BIT_9600 = 5208;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous UART line. Resets to the idle
// (high) level so releasing reset can never look like a start edge.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], i_d};
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 UART byte receiver: mid-bit sampling, one-cycle byte/frame-error strobes,
// and break suppression by waiting for the line to return high.
module uart_char_rx
  import gps_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_finished,
  output logic       o_frame_err
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       char_q, char_d;
  logic             fin_q, fin_d;
  logic             ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      char_q  <= '0;
      fin_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      fin_q   <= fin_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    char_d  = char_q;
    fin_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      // Re-check the start bit at its middle; a short low pulse is discarded.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Leaving at mid-stop-bit leaves half a bit of slack to catch the next start edge.
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            char_d  = shift_q;
            fin_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_char      = char_q;
  assign o_finished  = fin_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// Randomised + directed bench for uart_char_rx: driver pushes the expected
// strobe per frame, an independent monitor pops and checks on every strobe.
module tb_uart_char_rx;

  localparam int CPB     = 16;
  localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_char;
  logic       fin, ferr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       err;
    logic [7:0] ch;
    int         start;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_char_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx        (rx),
    .o_char      (o_char),
    .o_finished  (fin),
    .o_frame_err (ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A frame with a bad stop bit reports a frame error and leaves the last good byte visible.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
    exp_t e;
    if (stop_ok) last_good = b;
    e.err   = !stop_ok;
    e.ch    = last_good;
    e.start = cyc;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (!stop_ok) begin
      repeat (hold_low) @(posedge clk);
      #1;
      idle(6);
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 4 * CPB && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(nm, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_n && (fin || ferr)) begin
      chk("exclusive_strobes", {31'd0, fin & ferr}, 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, fin, ferr}, 0);
      end else begin
        e = sb.pop_front();
        chk("strobe_is_frame_err", {31'd0, ferr}, {31'd0, e.err});
        chk("o_char", {24'd0, o_char}, {24'd0, e.ch});
        d = cyc - e.start;
        total++;
        if (d < LAT_NOM - 1 || d > LAT_NOM + 3) begin
          bad++;
          $display("FAIL latency: got %0d cycles expected %0d..%0d", d, LAT_NOM - 1, LAT_NOM + 3);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    logic [7:0] msg [3];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_o_char", {24'd0, o_char}, 0);
    chk("reset_o_finished", {31'd0, fin}, 0);
    chk("reset_o_frame_err", {31'd0, ferr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(CPB);

    send_frame(8'h24, 1'b1, 0);
    idle(CPB);
    drain("single_dollar");

    msg[0] = 8'h24; msg[1] = 8'h47; msg[2] = 8'h2A;
    for (int i = 0; i < 3; i++) send_frame(msg[i], 1'b1, 0);
    idle(CPB);
    drain("back_to_back");

    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(3 * CPB);
    send_frame(8'h0D, 1'b1, 0);
    idle(CPB);
    drain("glitch_then_cr");

    send_frame(8'h41, 1'b1, 0);
    send_frame(8'h55, 1'b0, 0);
    idle(CPB);
    drain("frame_err");

    send_frame(8'h41, 1'b1, 0);
    send_frame(8'h55, 1'b0, 40);
    send_frame(8'h4E, 1'b1, 0);
    idle(CPB);
    drain("break_hold");

    b = 8'h0A;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (CPB / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("midreset_o_char", {24'd0, o_char}, 0);
    chk("midreset_o_finished", {31'd0, fin}, 0);
    chk("midreset_o_frame_err", {31'd0, ferr}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    last_good = 8'h00;
    idle(12 * CPB);
    chk("after_reset_o_char", {24'd0, o_char}, 0);
    send_frame(8'h0D, 1'b1, 0);
    idle(CPB);
    drain("after_reset");

    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, ok ? 0 : int'($urandom_range(0, 40)));
      idle(int'($urandom_range(0, CPB)));
    end
    idle(CPB);
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
